// File: rtl/axi3_mem_arbiter_pkg.sv
// Shared AXI3 bundle types, FSM state encodings and requester index map for
// the cache-side memory arbiter.
package axi3_mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int STRB_W = DATA_W / 8;

  // Requester slots; the granted slot index is also the ID driven on the bus.
  localparam int ICACHE_RD_IDX      = 0;
  localparam int DCACHE_RD_IDX      = 1;
  localparam int DCACHE_PASS_RD_IDX = 2;
  localparam int DCACHE_WR_IDX      = 0;
  localparam int DCACHE_PASS_WR_IDX = 1;

  typedef struct packed {
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              rready;
  } axi3_rd_req_t;

  typedef struct packed {
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
  } axi3_rd_resp_t;

  typedef struct packed {
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic [ID_W-1:0]   wid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              bready;
  } axi3_wr_req_t;

  typedef struct packed {
    logic              awready;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
  } axi3_wr_resp_t;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_arb_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi3_mem_arbiter_rr_arbiter.sv
// Rotating-priority picker: scan starts at ptr and wraps. Tying ptr to 0
// gives fixed lowest-index-wins priority.
module rr_arbiter
  import axi3_mem_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic hit;

  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    for (int i = 0; i < N; i++) begin
      if (!hit && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        idx    = IW'(i);
        hit    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!hit && req[i] && (i < int'(ptr))) begin
        gnt[i] = 1'b1;
        idx    = IW'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi3_mem_arbiter.sv
// Shares one AXI3 master port between cache requesters; read and write
// channels are arbitrated independently, one burst in flight per channel.
module axi3_mem_arbiter
  import axi3_mem_arbiter_pkg::*;
#(
  parameter int N_RD  = 3,
  parameter int N_WR  = 2,
  parameter bit RD_RR = 1'b1,
  parameter bit WR_RR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  axi3_rd_req_t  [N_RD-1:0] s_rd_req,
  output axi3_rd_resp_t [N_RD-1:0] s_rd_resp,
  input  axi3_wr_req_t  [N_WR-1:0] s_wr_req,
  output axi3_wr_resp_t [N_WR-1:0] s_wr_resp,
  output axi3_rd_req_t             m_rd_req,
  input  axi3_rd_resp_t            m_rd_resp,
  output axi3_wr_req_t             m_wr_req,
  input  axi3_wr_resp_t            m_wr_resp
);

  localparam int RIW = idx_w(N_RD);
  localparam int WIW = idx_w(N_WR);

  rd_arb_state_t   rd_state, rd_state_nxt;
  wr_arb_state_t   wr_state, wr_state_nxt;
  logic [RIW-1:0]  rd_g, rd_ptr, rd_arb_idx;
  logic [WIW-1:0]  wr_g, wr_ptr, wr_arb_idx;
  logic [N_RD-1:0] rd_reqv, rd_arb_oh, rd_arid_unused;
  logic [N_WR-1:0] wr_reqv, wr_arb_oh, wr_id_unused;
  logic            rd_any, wr_any;

  // Requester-supplied IDs are replaced by the slot index.
  for (genvar i = 0; i < N_RD; i++) begin : g_rd_req
    assign rd_reqv[i]        = s_rd_req[i].arvalid;
    assign rd_arid_unused[i] = ^s_rd_req[i].arid;
  end
  for (genvar i = 0; i < N_WR; i++) begin : g_wr_req
    assign wr_reqv[i]      = s_wr_req[i].awvalid;
    assign wr_id_unused[i] = ^{s_wr_req[i].awid, s_wr_req[i].wid};
  end

  rr_arbiter #(.N(N_RD), .IW(RIW)) u_rd_arb (
    .req (rd_reqv),
    .ptr (RD_RR ? rd_ptr : '0),
    .gnt (rd_arb_oh),
    .idx (rd_arb_idx)
  );

  rr_arbiter #(.N(N_WR), .IW(WIW)) u_wr_arb (
    .req (wr_reqv),
    .ptr (WR_RR ? wr_ptr : '0),
    .gnt (wr_arb_oh),
    .idx (wr_arb_idx)
  );

  assign rd_any = |rd_arb_oh;
  assign wr_any = |wr_arb_oh;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      rd_g     <= '0;
      rd_ptr   <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      if (rd_state == RD_IDLE && rd_any) rd_g <= rd_arb_idx;
      if (rd_state == RD_DATA && rd_state_nxt == RD_IDLE)
        rd_ptr <= (rd_g == RIW'(N_RD - 1)) ? '0 : rd_g + 1'b1;
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    m_rd_req     = '0;
    s_rd_resp    = '0;
    case (rd_state)
      RD_IDLE: if (rd_any) rd_state_nxt = RD_ADDR;
      RD_ADDR: begin
        m_rd_req.arid           = ID_W'(rd_g);
        m_rd_req.araddr         = s_rd_req[rd_g].araddr;
        m_rd_req.arlen          = s_rd_req[rd_g].arlen;
        m_rd_req.arsize         = s_rd_req[rd_g].arsize;
        m_rd_req.arburst        = s_rd_req[rd_g].arburst;
        m_rd_req.arvalid        = s_rd_req[rd_g].arvalid;
        s_rd_resp[rd_g].arready = m_rd_resp.arready;
        if (s_rd_req[rd_g].arvalid && m_rd_resp.arready) rd_state_nxt = RD_DATA;
      end
      RD_DATA: begin
        m_rd_req.rready        = s_rd_req[rd_g].rready;
        s_rd_resp[rd_g].rid    = m_rd_resp.rid;
        s_rd_resp[rd_g].rdata  = m_rd_resp.rdata;
        s_rd_resp[rd_g].rresp  = m_rd_resp.rresp;
        s_rd_resp[rd_g].rlast  = m_rd_resp.rlast;
        s_rd_resp[rd_g].rvalid = m_rd_resp.rvalid;
        if (m_rd_resp.rvalid && s_rd_req[rd_g].rready && m_rd_resp.rlast)
          rd_state_nxt = RD_IDLE;
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      wr_g     <= '0;
      wr_ptr   <= '0;
    end else begin
      wr_state <= wr_state_nxt;
      if (wr_state == WR_IDLE && wr_any) wr_g <= wr_arb_idx;
      if (wr_state == WR_RESP && wr_state_nxt == WR_IDLE)
        wr_ptr <= (wr_g == WIW'(N_WR - 1)) ? '0 : wr_g + 1'b1;
    end
  end

  // W is only forwarded in WR_DATA, so bursts cannot interleave on the bus.
  always_comb begin
    wr_state_nxt = wr_state;
    m_wr_req     = '0;
    s_wr_resp    = '0;
    case (wr_state)
      WR_IDLE: if (wr_any) wr_state_nxt = WR_ADDR;
      WR_ADDR: begin
        m_wr_req.awid           = ID_W'(wr_g);
        m_wr_req.awaddr         = s_wr_req[wr_g].awaddr;
        m_wr_req.awlen          = s_wr_req[wr_g].awlen;
        m_wr_req.awsize         = s_wr_req[wr_g].awsize;
        m_wr_req.awburst        = s_wr_req[wr_g].awburst;
        m_wr_req.awvalid        = s_wr_req[wr_g].awvalid;
        s_wr_resp[wr_g].awready = m_wr_resp.awready;
        if (s_wr_req[wr_g].awvalid && m_wr_resp.awready) wr_state_nxt = WR_DATA;
      end
      WR_DATA: begin
        m_wr_req.wid           = ID_W'(wr_g);
        m_wr_req.wdata         = s_wr_req[wr_g].wdata;
        m_wr_req.wstrb         = s_wr_req[wr_g].wstrb;
        m_wr_req.wlast         = s_wr_req[wr_g].wlast;
        m_wr_req.wvalid        = s_wr_req[wr_g].wvalid;
        s_wr_resp[wr_g].wready = m_wr_resp.wready;
        if (s_wr_req[wr_g].wvalid && m_wr_resp.wready && s_wr_req[wr_g].wlast)
          wr_state_nxt = WR_RESP;
      end
      WR_RESP: begin
        m_wr_req.bready        = s_wr_req[wr_g].bready;
        s_wr_resp[wr_g].bid    = m_wr_resp.bid;
        s_wr_resp[wr_g].bresp  = m_wr_resp.bresp;
        s_wr_resp[wr_g].bvalid = m_wr_resp.bvalid;
        if (m_wr_resp.bvalid && s_wr_req[wr_g].bready) wr_state_nxt = WR_IDLE;
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi3_mem_arbiter.sv
// Directed bench for axi3_mem_arbiter: a round-robin instance plus a
// fixed-priority instance driven with the same requester and bus stimulus.
module tb_axi3_mem_arbiter;
  import axi3_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  axi3_rd_req_t  [2:0] s_rd_req;
  axi3_rd_resp_t [2:0] s_rd_resp, f_s_rd_resp;
  axi3_wr_req_t  [1:0] s_wr_req;
  axi3_wr_resp_t [1:0] s_wr_resp, f_s_wr_resp;
  axi3_rd_req_t        m_rd_req, f_m_rd_req;
  axi3_rd_resp_t       m_rd_resp;
  axi3_wr_req_t        m_wr_req, f_m_wr_req;
  axi3_wr_resp_t       m_wr_resp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi3_mem_arbiter #(.N_RD(3), .N_WR(2), .RD_RR(1'b1), .WR_RR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .s_rd_req(s_rd_req), .s_rd_resp(s_rd_resp),
    .s_wr_req(s_wr_req), .s_wr_resp(s_wr_resp),
    .m_rd_req(m_rd_req), .m_rd_resp(m_rd_resp),
    .m_wr_req(m_wr_req), .m_wr_resp(m_wr_resp)
  );

  axi3_mem_arbiter #(.N_RD(3), .N_WR(2), .RD_RR(1'b0), .WR_RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .s_rd_req(s_rd_req), .s_rd_resp(f_s_rd_resp),
    .s_wr_req(s_wr_req), .s_wr_resp(f_s_wr_resp),
    .m_rd_req(f_m_rd_req), .m_rd_resp(m_rd_resp),
    .m_wr_req(f_m_wr_req), .m_wr_resp(m_wr_resp)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_all();
    s_rd_req  = '0;
    s_wr_req  = '0;
    m_rd_resp = '0;
    m_wr_resp = '0;
  endtask

  initial begin
    int exp_g [4];
    logic [6:0] bp;
    logic [4:0] wp;
    int b, bb, got;
    logic hs;
    exp_g = '{0, 1, 2, 0};
    bp = 7'b1110001;
    wp = 5'b11101;

    // ---- reset state
    clr_all();
    rst = 1'b1;
    tick(); tick();
    chk("rst_m_rd_req", m_rd_req, '0);
    chk("rst_s_rd_resp", s_rd_resp, '0);
    chk("rst_m_wr_req", m_wr_req, '0);
    chk("rst_s_wr_resp", s_wr_resp, '0);
    chk("rst_rd_state", dut.rd_state, RD_IDLE);
    chk("rst_wr_state", dut.wr_state, WR_IDLE);
    rst = 1'b0;

    // ---- single 8-beat read from idx1, bus arready on 2nd ADDR cycle
    s_rd_req[1].arvalid = 1'b1;
    s_rd_req[1].araddr  = 32'h1000_0040;
    s_rd_req[1].arlen   = 4'd7;
    s_rd_req[1].arid    = 4'hF;
    s_rd_req[1].rready  = 1'b1;
    #1;
    chk("rd1_arb_latency", m_rd_req.arvalid, 1'b0);
    tick();
    chk("rd1_arvalid", m_rd_req.arvalid, 1'b1);
    chk("rd1_arid", m_rd_req.arid, 4'd1);
    chk("rd1_araddr", m_rd_req.araddr, 32'h1000_0040);
    chk("rd1_arlen", m_rd_req.arlen, 4'd7);
    chk("rd1_arready_wait", s_rd_resp[1].arready, 1'b0);
    tick();
    m_rd_resp.arready = 1'b1;
    #1;
    chk("rd1_arready", s_rd_resp[1].arready, 1'b1);
    chk("rd1_arready_other", {s_rd_resp[2].arready, s_rd_resp[0].arready}, 2'b00);
    tick();
    s_rd_req[1].arvalid = 1'b0;
    m_rd_resp.arready   = 1'b0;
    for (b = 0; b < 8; b++) begin
      m_rd_resp.rvalid = 1'b1;
      m_rd_resp.rdata  = 32'hA0 + b;
      m_rd_resp.rlast  = (b == 7);
      #1;
      chk("rd1_rvalid", s_rd_resp[1].rvalid, 1'b1);
      chk("rd1_rdata", s_rd_resp[1].rdata, 32'hA0 + b);
      chk("rd1_rlast", s_rd_resp[1].rlast, (b == 7));
      chk("rd1_rvalid_other", {s_rd_resp[2].rvalid, s_rd_resp[0].rvalid}, 2'b00);
      tick();
    end
    m_rd_resp = '0;
    #1;
    chk("rd1_back_idle", dut.rd_state, RD_IDLE);
    clr_all();

    // ---- round-robin contention, 1-beat bursts (pointer reset to 0 first)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_rd_req[i].arvalid = 1'b1;
      s_rd_req[i].rready  = 1'b1;
    end
    m_rd_resp.arready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("rr_arid", m_rd_req.arid, exp_g[t]);
      chk("fp_arid", f_m_rd_req.arid, 4'd0);
      tick();
      m_rd_resp.rvalid = 1'b1;
      m_rd_resp.rlast  = 1'b1;
      m_rd_resp.rdata  = 32'h50 + t;
      #1;
      chk("rr_rvalid_grantee", s_rd_resp[exp_g[t]].rvalid, 1'b1);
      chk("fp_rvalid_idx0", f_s_rd_resp[0].rvalid, 1'b1);
      tick();
      m_rd_resp.rvalid = 1'b0;
    end
    clr_all();

    // ---- 4-beat write from idx0, wready 1,0,1,1,1
    s_wr_req[0].awvalid = 1'b1;
    s_wr_req[0].awaddr  = 32'h2000_0080;
    s_wr_req[0].awlen   = 4'd3;
    s_wr_req[0].wvalid  = 1'b1;
    s_wr_req[0].wstrb   = 4'hF;
    s_wr_req[0].bready  = 1'b1;
    m_wr_resp.awready   = 1'b1;
    tick();
    chk("wr_awvalid", m_wr_req.awvalid, 1'b1);
    chk("wr_awid", m_wr_req.awid, 4'd0);
    chk("wr_awlen", m_wr_req.awlen, 4'd3);
    chk("wr_awready0", s_wr_resp[0].awready, 1'b1);
    chk("wr_awready1", s_wr_resp[1].awready, 1'b0);
    tick();
    s_wr_req[0].awvalid = 1'b0;
    m_wr_resp.awready   = 1'b0;
    b = 0;
    for (int c = 0; c < 5; c++) begin
      s_wr_req[0].wdata = 32'hD0 + b;
      s_wr_req[0].wlast = (b == 3);
      m_wr_resp.wready  = wp[c];
      #1;
      chk("wr_wvalid", m_wr_req.wvalid, 1'b1);
      chk("wr_wdata", m_wr_req.wdata, 32'hD0 + b);
      chk("wr_wlast", m_wr_req.wlast, (b == 3));
      chk("wr_wid", m_wr_req.wid, 4'd0);
      chk("wr_wready", s_wr_resp[0].wready, wp[c]);
      chk("wr_awready1_data", s_wr_resp[1].awready, 1'b0);
      tick();
      if (wp[c]) b++;
    end
    m_wr_resp.wready = 1'b0;
    m_wr_resp.bvalid = 1'b1;
    m_wr_resp.bid    = 4'd0;
    #1;
    chk("wr_bvalid0", s_wr_resp[0].bvalid, 1'b1);
    chk("wr_bvalid1", s_wr_resp[1].bvalid, 1'b0);
    chk("wr_bready", m_wr_req.bready, 1'b1);
    chk("wr_no_w_in_resp", m_wr_req.wvalid, 1'b0);
    tick();
    m_wr_resp.bvalid = 1'b0;
    #1;
    chk("wr_back_idle", dut.wr_state, WR_IDLE);
    clr_all();

    // ---- concurrent: dcache_pass 1-beat write and icache 8-beat read
    s_rd_req[ICACHE_RD_IDX].arvalid = 1'b1;
    s_rd_req[ICACHE_RD_IDX].arlen   = 4'd7;
    s_rd_req[ICACHE_RD_IDX].rready  = 1'b1;
    s_wr_req[DCACHE_PASS_WR_IDX].awvalid = 1'b1;
    s_wr_req[DCACHE_PASS_WR_IDX].wvalid  = 1'b1;
    s_wr_req[DCACHE_PASS_WR_IDX].wlast   = 1'b1;
    s_wr_req[DCACHE_PASS_WR_IDX].wdata   = 32'h77;
    s_wr_req[DCACHE_PASS_WR_IDX].bready  = 1'b1;
    m_rd_resp.arready = 1'b1;
    m_wr_resp.awready = 1'b1;
    m_wr_resp.wready  = 1'b1;
    tick();
    chk("cc_arid", m_rd_req.arid, 4'd0);
    chk("cc_awid", m_wr_req.awid, 4'd1);
    tick();
    s_rd_req[ICACHE_RD_IDX].arvalid = 1'b0;
    s_wr_req[DCACHE_PASS_WR_IDX].awvalid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      m_rd_resp.rvalid = 1'b1;
      m_rd_resp.rdata  = 32'hC0 + k;
      m_rd_resp.rlast  = (k == 7);
      m_wr_resp.bvalid = (k == 1);
      m_wr_resp.bid    = 4'd1;
      #1;
      chk("cc_rdata", s_rd_resp[0].rdata, 32'hC0 + k);
      if (k == 0) begin
        chk("cc_wvalid", m_wr_req.wvalid, 1'b1);
        chk("cc_wid", m_wr_req.wid, 4'd1);
        chk("cc_wdata", m_wr_req.wdata, 32'h77);
      end
      if (k == 1) begin
        chk("cc_bvalid_pass", s_wr_resp[1].bvalid, 1'b1);
        chk("cc_bid_pass", s_wr_resp[1].bid, 4'd1);
        chk("cc_bvalid_dc", s_wr_resp[0].bvalid, 1'b0);
      end
      if (k == 2) begin
        chk("cc_wr_done_first", dut.wr_state, WR_IDLE);
        chk("cc_rd_still_busy", dut.rd_state, RD_DATA);
      end
      tick();
    end
    chk("cc_rd_done", dut.rd_state, RD_IDLE);
    clr_all();

    // ---- reset during beat 3 of an 8-beat read from idx2
    s_rd_req[2].arvalid = 1'b1;
    s_rd_req[2].arlen   = 4'd7;
    s_rd_req[2].rready  = 1'b1;
    m_rd_resp.arready   = 1'b1;
    tick();
    chk("mr_arid", m_rd_req.arid, 4'd2);
    tick();
    s_rd_req[2].arvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_rd_resp.rvalid = 1'b1;
      m_rd_resp.rdata  = 32'hE0 + k;
      if (k == 2) rst = 1'b1;
      #1;
      chk("mr_rdata", s_rd_resp[2].rdata, 32'hE0 + k);
      tick();
    end
    chk("mr_rd_state", dut.rd_state, RD_IDLE);
    chk("mr_m_rd_req", m_rd_req, '0);
    chk("mr_s_rd_resp", s_rd_resp, '0);
    rst = 1'b0;
    m_rd_resp.rvalid = 1'b0;
    s_rd_req[0].arvalid = 1'b1;
    s_rd_req[0].arlen   = 4'd0;
    s_rd_req[0].rready  = 1'b1;
    tick();
    chk("mr_regrant_valid", m_rd_req.arvalid, 1'b1);
    chk("mr_regrant_arid", m_rd_req.arid, 4'd0);
    tick();
    s_rd_req[0].arvalid = 1'b0;
    m_rd_resp.rvalid = 1'b1;
    m_rd_resp.rlast  = 1'b1;
    tick();
    clr_all();

    // ---- back-pressure: idx1 4-beat read, rready 1,0,0,0,1,1,1
    s_rd_req[1].arvalid = 1'b1;
    s_rd_req[1].arlen   = 4'd3;
    m_rd_resp.arready   = 1'b1;
    tick();
    chk("bp_arid", m_rd_req.arid, 4'd1);
    tick();
    s_rd_req[1].arvalid = 1'b0;
    m_rd_resp.arready   = 1'b0;
    bb = 0;
    got = 0;
    for (int c = 0; c < 7; c++) begin
      s_rd_req[1].rready = bp[c];
      m_rd_resp.rvalid   = 1'b1;
      m_rd_resp.rdata    = 32'hB0 + bb;
      m_rd_resp.rlast    = (bb == 3);
      #1;
      chk("bp_m_rready", m_rd_req.rready, bp[c]);
      if (bp[c]) begin
        chk("bp_beat_order", s_rd_resp[1].rdata, 32'hB0 + got);
        got++;
      end
      hs = m_rd_req.rready;
      tick();
      if (hs) bb++;
    end
    chk("bp_done_idle", dut.rd_state, RD_IDLE);
    chk("bp_no_extra_beat", s_rd_resp[1].rvalid, 1'b0);
    clr_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
